// File: rtl/tagged_fifo.sv
// Multi-flux tagged FIFO: steers {tag,data} writes into per-flux circular queues
// and presents per-flux empty flags plus a first-word-fall-through head word.
module tagged_fifo #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = $clog2(FLUX),
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic [FLUX-1:0]  read,
  output logic [FLUX-1:0]  empty,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem    [FLUX][DEPTH];
  logic [PTR_W-1:0]      wr_ptr [FLUX];
  logic [PTR_W-1:0]      rd_ptr [FLUX];
  logic [CNT_W-1:0]      cnt    [FLUX];

  logic [TAG_WIDTH-1:0]  wr_tag;
  logic [FLUX-1:0]       q_full;
  logic [FLUX-1:0]       wr_en;
  logic [FLUX-1:0]       rd_en;
  logic                  found;

  assign wr_tag = din[WIDTH-1 -: TAG_WIDTH];

  // Flags decode registered counts only, so the producer/consumer can
  // build write/read from them without a combinational loop.
  always_comb begin
    q_full = '0;
    empty  = '0;
    wr_en  = '0;
    rd_en  = '0;
    for (int unsigned i = 0; i < FLUX; i++) begin
      q_full[i] = (cnt[i] == CNT_W'(DEPTH));
      empty[i]  = (cnt[i] == '0);
    end
    full = |q_full;
    for (int unsigned i = 0; i < FLUX; i++) begin
      wr_en[i] = write && !full && (wr_tag == TAG_WIDTH'(i));
      rd_en[i] = read[i] && !empty[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FLUX; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < FLUX; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        cnt[i] <= cnt[i] + CNT_W'(wr_en[i]) - CNT_W'(rd_en[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < FLUX; i++) begin
      if (wr_en[i]) mem[i][wr_ptr[i]] <= din[DATA_WIDTH-1:0];
    end
  end

  // read acts purely as a priority select; an empty selected queue yields 0.
  always_comb begin
    dout  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < FLUX; i++) begin
      if (!found && ((|read) ? read[i] : !empty[i])) begin
        found = 1'b1;
        if (!empty[i]) dout = {TAG_WIDTH'(i), mem[i][rd_ptr[i]]};
      end
    end
  end

  tag_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    (write && !full) |-> (int'(wr_tag) < FLUX));

endmodule
